// File: rtl/opb_register_ppc2simulink_1clk.sv
// opb_register_ppc2simulink_1clk
// Software-writable 32-bit control register on the OPB bus, driven out to
// fabric logic as user_data_out with a one-cycle user_data_valid strobe.
// Single clock (OPB_Clk), asynchronous active-low reset.
//
// Build option:
//   OPB_REG_SHADOW_EN  - DATA writes land in a staging register and reach
//                        user_data_out only when CTRL bit 31 (bus order) is
//                        written with 1. Without it, staging and the output
//                        are one register and every DATA write is visible.
//
// Bus vectors use OPB big-endian numbering ([0:31], bit 0 = MSB). Internally
// everything is held as [31:0] numeric vectors, so bus bit i is numeric bit
// 31-i and bus byte lane k (BE[k]) is numeric byte 3-k.
module opb_register_ppc2simulink_1clk #(
  parameter logic [31:0] C_BASEADDR   = 32'h01004400,
  parameter logic [31:0] C_HIGHADDR   = 32'h010044FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter logic [31:0] C_INIT       = 32'h00000000,
  parameter string       C_FAMILY     = "virtex6"
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst_n,
  input  logic [0:31] OPB_ABus,
  input  logic [0:3]  OPB_BE,
  input  logic [0:31] OPB_DBus,
  input  logic        OPB_RNW,
  input  logic        OPB_select,
  input  logic        OPB_seqAddr,
  output logic [0:31] Sl_DBus,
  output logic        Sl_xferAck,
  output logic        Sl_errAck,
  output logic        Sl_retry,
  output logic        Sl_toutSup,
  output logic [31:0] user_data_out,
  output logic        user_data_valid
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ACK  = 1'b1
  } state_t;

  // Merge write data into the current value, one byte per asserted enable.
  // be[j] gates numeric byte j (be is the bus BE vector seen as [3:0]).
  function automatic logic [31:0] byte_merge(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = cur;
    for (int j = 0; j < 4; j++) begin
      if (be[j]) res[8*j +: 8] = wd[8*j +: 8];
    end
    return res;
  endfunction

  state_t      state_q;
  state_t      state_d;

  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        in_window;
  logic        known_off;
  logic        sel_data;
  logic        sel_ctrl;
  logic        hit;
  logic        wr_hit;
  logic        rd_hit;
  logic        data_wr;
  logic [31:0] merged;
  logic [31:0] staging;
  logic [31:0] rd_next;
  logic [31:0] rd_data_p1;
  logic        vld_p1;
  logic        unused_cfg;

  assign bus_wdata = OPB_DBus;
  assign bus_be    = OPB_BE;

  // Address decode: window check, then the two known words. ABus[30:31]
  // (byte within word) play no part in word selection.
  assign in_window = (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
  assign known_off = ((OPB_ABus - C_BASEADDR) < 32'd8);
  assign sel_data  = known_off && !OPB_ABus[29];
  assign sel_ctrl  = known_off &&  OPB_ABus[29];

  // Select is only looked at in IDLE, so a master that keeps select high
  // through the ack cycle is never acknowledged twice.
  assign hit     = (state_q == S_IDLE) && OPB_select && in_window;
  assign wr_hit  = hit && !OPB_RNW;
  assign rd_hit  = hit &&  OPB_RNW;
  assign data_wr = wr_hit && sel_data && (bus_be != 4'b0000);
  assign merged  = byte_merge(staging, bus_wdata, bus_be);

`ifdef OPB_REG_SHADOW_EN
  logic [31:0] shadow_out;
  logic        commit;
  logic        pending;
  logic [31:0] status_word;

  // Commit is bus bit 31, i.e. the numeric LSB of the write data.
  assign commit      = wr_hit && sel_ctrl && OPB_DBus[31];
  assign pending     = (staging != shadow_out);
  assign status_word = {31'b0, pending};

  // Read mux: values as they stood before this edge's write takes effect.
  always_comb begin
    rd_next = 32'h0;
    if (rd_hit) begin
      if (sel_data)      rd_next = staging;
      else if (sel_ctrl) rd_next = status_word;
    end
  end

  // Output register, loaded from staging only on a commit.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) shadow_out <= C_INIT;
    else if (commit) shadow_out <= staging;
  end

  // Update strobe follows every commit, even one that changes nothing.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) vld_p1 <= 1'b0;
    else            vld_p1 <= commit;
  end

  assign user_data_out = shadow_out;
`else
  logic unused_ctrl;

  // CTRL has no function here: it reads 0 and writes to it are dropped.
  assign unused_ctrl = sel_ctrl;

  // Read mux: DATA only, value as it stood before this edge's write.
  always_comb begin
    rd_next = 32'h0;
    if (rd_hit && sel_data) rd_next = staging;
  end

  // Update strobe follows every DATA write that enables at least one byte.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) vld_p1 <= 1'b0;
    else            vld_p1 <= data_wr;
  end

  assign user_data_out = staging;
`endif

  // FSM state register.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // FSM next state: a hit moves to ACK, ACK always returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (hit) state_d = S_ACK;
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---- stage boundary: hit sampled (N) -> ack cycle (N+1) ----

  // Staging register takes byte-merged write data on a DATA hit.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n)   staging <= C_INIT;
    else if (data_wr) staging <= merged;
  end

  // Read data captured on the hit edge, presented during the ack cycle.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) rd_data_p1 <= 32'h0;
    else            rd_data_p1 <= rd_next;
  end

  assign Sl_xferAck      = (state_q == S_ACK);
  assign Sl_DBus         = Sl_xferAck ? rd_data_p1 : 32'h0;
  assign Sl_errAck       = 1'b0;
  assign Sl_retry        = 1'b0;
  assign Sl_toutSup      = 1'b0;
  assign user_data_valid = vld_p1;

  // Informational configuration and the ignored seqAddr input.
  assign unused_cfg = OPB_seqAddr | (C_OPB_AWIDTH != 32) | (C_OPB_DWIDTH != 32)
                    | (C_FAMILY == "");

endmodule

// File: tb/tb_opb_register_ppc2simulink_1clk.sv
// Testbench for opb_register_ppc2simulink_1clk. Read data expectations are
// queued when a transfer is driven and checked when the ack appears.
// Expectations follow OPB_REG_SHADOW_EN if it is defined for the build.
module tb_opb_register_ppc2simulink_1clk;

  localparam logic [31:0] BASE = 32'h01004400;
  localparam logic [31:0] HIGH = 32'h010044FF;
  localparam logic [31:0] INIT = 32'hA5A50001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:31] abus;
  logic [0:3]  be;
  logic [0:31] dbus;
  logic        rnw;
  logic        sel;
  logic        seq;
  logic [0:31] sl_dbus;
  logic        ack;
  logic        err;
  logic        retry;
  logic        tout;
  logic [31:0] udo;
  logic        udv;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  opb_register_ppc2simulink_1clk #(
    .C_BASEADDR  (BASE),
    .C_HIGHADDR  (HIGH),
    .C_INIT      (INIT)
  ) dut (
    .OPB_Clk         (clk),
    .OPB_Rst_n       (rst_n),
    .OPB_ABus        (abus),
    .OPB_BE          (be),
    .OPB_DBus        (dbus),
    .OPB_RNW         (rnw),
    .OPB_select      (sel),
    .OPB_seqAddr     (seq),
    .Sl_DBus         (sl_dbus),
    .Sl_xferAck      (ack),
    .Sl_errAck       (err),
    .Sl_retry        (retry),
    .Sl_toutSup      (tout),
    .user_data_out   (udo),
    .user_data_valid (udv)
  );

  // Scoreboard: every ack pops one expectation; no ack means bus data is 0.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      if (ack === 1'b1) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected_ack got Sl_DBus=%h want no ack", sl_dbus);
        end else begin
          mon_exp = exp_q.pop_front();
          if (sl_dbus !== mon_exp) begin
            bad++;
            $display("FAIL sb_rdata got=%h want=%h", sl_dbus, mon_exp);
          end
        end
      end else if (sl_dbus !== 32'h0) begin
        bad++;
        $display("FAIL sb_idle_dbus got=%h want=00000000", sl_dbus);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_bus();
    sel  = 1'b0;
    abus = '0;
    dbus = '0;
    be   = '0;
    rnw  = 1'b0;
  endtask

  // One transfer; returns at the negedge of the expected ack cycle.
  task automatic xfer(input string nm, input logic [31:0] addr, input logic r,
                      input logic [3:0] b, input logic [31:0] wd,
                      input logic [31:0] exp_rd);
    @(negedge clk);
    abus = addr; rnw = r; be = b; dbus = wd; sel = 1'b1;
    exp_q.push_back(r ? exp_rd : 32'h0);
    @(negedge clk);
    total++;
    if (ack !== 1'b1) begin
      bad++;
      $display("FAIL %s_ack got=%b want=1", nm, ack);
    end
    idle_bus();
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_bus();
    seq = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_udo", udo, INIT);
    chk("rst_ack", {31'b0, ack}, 32'h0);
    chk("rst_dbus", sl_dbus, 32'h0);
    chk("rst_err_retry_tout", {29'b0, err, retry, tout}, 32'h0);
    chk("rst_valid", {31'b0, udv}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_write_read();
    xfer("wr_full", BASE, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0);
`ifdef OPB_REG_SHADOW_EN
    chk("full_valid", {31'b0, udv}, 32'h0);
    chk("full_udo", udo, INIT);
`else
    chk("full_valid", {31'b0, udv}, 32'h1);
    chk("full_udo", udo, 32'hDEADBEEF);
`endif
    @(negedge clk);
    chk("full_valid_drop", {31'b0, udv}, 32'h0);
    xfer("rd_full", BASE, 1'b1, 4'b1111, 32'h0, 32'hDEADBEEF);
`ifdef OPB_REG_SHADOW_EN
    xfer("rd_ctrl_pending", BASE + 32'h4, 1'b1, 4'b1111, 32'h0, 32'h1);
`else
    xfer("rd_ctrl_plain", BASE + 32'h4, 1'b1, 4'b1111, 32'h0, 32'h0);
`endif
  endtask

  task automatic test_byte_merge();
    xfer("wr_zero", BASE, 1'b0, 4'b1111, 32'h0, 32'h0);
    xfer("wr_merge", BASE, 1'b0, 4'b0101, 32'h11223344, 32'h0);
`ifndef OPB_REG_SHADOW_EN
    chk("merge_udo", udo, 32'h00220044);
    chk("merge_valid", {31'b0, udv}, 32'h1);
`endif
    xfer("rd_merge", BASE, 1'b1, 4'b1111, 32'h0, 32'h00220044);
    xfer("wr_be0", BASE, 1'b0, 4'b0000, 32'hFFFFFFFF, 32'h0);
    chk("be0_valid", {31'b0, udv}, 32'h0);
    xfer("rd_be0", BASE, 1'b1, 4'b1111, 32'h0, 32'h00220044);
  endtask

  task automatic test_commit();
`ifdef OPB_REG_SHADOW_EN
    chk("pre_commit_udo", udo, INIT);
    xfer("wr_commit", BASE + 32'h4, 1'b0, 4'b1111, 32'h1, 32'h0);
    chk("commit_udo", udo, 32'h00220044);
    chk("commit_valid", {31'b0, udv}, 32'h1);
    @(negedge clk);
    chk("commit_valid_drop", {31'b0, udv}, 32'h0);
    xfer("rd_ctrl_clear", BASE + 32'h4, 1'b1, 4'b1111, 32'h0, 32'h0);
    xfer("wr_commit_same", BASE + 32'h4, 1'b0, 4'b1111, 32'h1, 32'h0);
    chk("same_commit_valid", {31'b0, udv}, 32'h1);
    chk("same_commit_udo", udo, 32'h00220044);
`else
    xfer("wr_ctrl_ignored", BASE + 32'h4, 1'b0, 4'b1111, 32'h1, 32'h0);
    chk("ctrl_ignored_valid", {31'b0, udv}, 32'h0);
    chk("ctrl_ignored_udo", udo, 32'h00220044);
    xfer("rd_ctrl_zero", BASE + 32'h4, 1'b1, 4'b1111, 32'h0, 32'h0);
`endif
  endtask

  task automatic test_protocol();
    int acks;
    int ack_cyc[$];
    // Select kept high through the ack cycle: still only one ack.
    @(negedge clk);
    abus = BASE; rnw = 1'b1; be = 4'b1111; sel = 1'b1;
    exp_q.push_back(32'h00220044);
    acks = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
    end
    idle_bus();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
    end
    chk("held_select_acks", acks, 1);

    // Just above the window: never acked.
    @(negedge clk);
    abus = HIGH + 32'h4; rnw = 1'b1; be = 4'b1111; sel = 1'b1;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ack === 1'b1) acks++;
    end
    idle_bus();
    chk("miss_acks", acks, 0);

    // Unmapped offset inside the window: acked, reads 0, writes dropped.
    xfer("rd_off8", BASE + 32'h8, 1'b1, 4'b1111, 32'h0, 32'h0);
    xfer("wr_off8", BASE + 32'h8, 1'b0, 4'b1111, 32'hFFFFFFFF, 32'h0);
    xfer("rd_after_off8", BASE, 1'b1, 4'b1111, 32'h0, 32'h00220044);

    // Back-to-back reads with select never dropped.
    @(negedge clk);
    abus = BASE; rnw = 1'b1; be = 4'b1111; sel = 1'b1;
    exp_q.push_back(32'h00220044);
    for (int i = 0; i < 8 && ack_cyc.size() < 2; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        ack_cyc.push_back(cyc);
        if (ack_cyc.size() == 1) begin
          abus = BASE + 32'h8;
          exp_q.push_back(32'h0);
        end else begin
          idle_bus();
        end
      end
    end
    idle_bus();
    chk("b2b_ack_count", ack_cyc.size(), 2);
    if (ack_cyc.size() == 2) chk("b2b_spacing", ack_cyc[1] - ack_cyc[0], 2);
    @(negedge clk);
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    abus = BASE; rnw = 1'b0; be = 4'b1111; dbus = 32'h12345678; sel = 1'b1;
    exp_q.push_back(32'h0);
    @(negedge clk);
    chk("midop_ack_before", {31'b0, ack}, 32'h1);
`ifdef OPB_REG_SHADOW_EN
    chk("midop_valid_before", {31'b0, udv}, 32'h0);
`else
    chk("midop_valid_before", {31'b0, udv}, 32'h1);
`endif
    idle_bus();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midop_ack_after", {31'b0, ack}, 32'h0);
    chk("midop_valid_after", {31'b0, udv}, 32'h0);
    chk("midop_udo_after", udo, INIT);
    chk("midop_dbus_after", sl_dbus, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xfer("rd_after_reset", BASE, 1'b1, 4'b1111, 32'h0, INIT);
`ifdef OPB_REG_SHADOW_EN
    xfer("rd_ctrl_after_reset", BASE + 32'h4, 1'b1, 4'b1111, 32'h0, 32'h0);
`endif
  endtask

  initial begin
    test_reset();
    test_full_write_read();
    test_byte_merge();
    test_commit();
    test_protocol();
    test_reset_midop();
    repeat (2) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
